nn_ctrl: RTL

Sequencer and configuration controller for the quantized QEC decoder network (`nn`). It loads weights and biases word-serially into a shadow buffer and commits them atomically once the network pipeline is empty. It issues syndromes into the network under valid/ready flow control, tracks in-flight samples through the network's fixed pipeline, and buffers the 2-bit decisions in a result FIFO sized so that no result is ever dropped.

---
 rtl/nn_pkg.sv | 16 +
 rtl/nn_res_fifo.sv | 32 +++
 rtl/nn_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared sizes, derived constants and FSM state type for the nn sequencer
package nn_pkg;
    localparam int N_INPUTS    = 4;
    localparam int N_LAYER_1   = 2;
    localparam int N_LAYER_2   = 2;
    localparam int WEIGHT_BITS = 3;
    localparam int NN_LATENCY  = 5;
    localparam int RES_DEPTH   = NN_LATENCY + 1;
    localparam int N_W   = N_INPUTS*N_LAYER_1 + N_LAYER_1*N_LAYER_2 + N_LAYER_2*2;
    localparam int N_B   = N_LAYER_1 + N_LAYER_2 + 2;
    localparam int N_CFG = N_W + N_B;
    localparam int CNT_W = $clog2(N_CFG);
    localparam int OCC_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = $clog2(RES_DEPTH);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMMIT, S_RUN} state_t;
endpackage

// File: rtl/nn_res_fifo.sv
// nn_res_fifo: RES_DEPTH x 2-bit result FIFO with occupancy count
//   push/push_data write the tail, pop advances the head, head is 0 when empty
module nn_res_fifo
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [1:0]       push_data,
    input  logic             pop,
    output logic [1:0]       head,
    output logic [OCC_W-1:0] count
);
    logic [1:0]       mem [RES_DEPTH];
    logic [PTR_W-1:0] wr, rd;

    assign head = count != '0 ? mem[rd] : 2'b00;

    always_ff @(posedge clk)
        if (push) mem[wr] <= push_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr == PTR_W'(RES_DEPTH-1) ? '0 : wr + 1'b1;
            if (pop) rd <= rd == PTR_W'(RES_DEPTH-1) ? '0 : rd + 1'b1;
            count <= count + OCC_W'(push) - OCC_W'(pop);
        end
endmodule

// File: rtl/nn_ctrl.sv
// nn_ctrl: config loader with atomic commit, syndrome issue and result buffering for nn
//   cfg_*: word-serial weight/bias stream; syn_*: syndrome stream; res_*: decision stream
//   nn_*: drive to and result from the fixed-latency network
module nn_ctrl
    import nn_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [WEIGHT_BITS-1:0]       cfg_data,
    input  logic                         cfg_last,
    output logic                         cfg_err,
    output logic                         cfg_loaded,
    input  logic                         syn_valid,
    output logic                         syn_ready,
    input  logic [N_INPUTS-1:0]          syn_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [1:0]                   res_data,
    output logic [N_INPUTS-1:0]          nn_inputs,
    output logic [N_W*WEIGHT_BITS-1:0]   nn_weights,
    output logic [N_B*WEIGHT_BITS-1:0]   nn_bias,
    input  logic [1:0]                   nn_outputs
);
    state_t                       state, ns;
    logic [CNT_W-1:0]             cnt;
    logic [N_CFG*WEIGHT_BITS-1:0] shadow;
    logic [NN_LATENCY-1:0]        tags;
    logic [OCC_W-1:0]             inflight, fifo_count;
    logic                         syn_en, cfg_fire, syn_fire, res_pop, emerge, last_word, frame_err;

    assign cfg_fire  = cfg_valid & cfg_ready;
    assign syn_fire  = syn_valid & syn_ready;
    assign res_valid = fifo_count != '0;
    assign res_pop   = res_valid & res_ready;
    assign emerge    = tags[NN_LATENCY-1];
    assign last_word = cnt == CNT_W'(N_CFG-1);
    assign frame_err = cfg_fire & (cfg_last != last_word);
    // Every in-flight tag owns a FIFO slot; a pop this edge frees one, which keeps full rate with res_ready high.
    assign syn_ready = syn_en & ((OCC_W+1)'(inflight) + (OCC_W+1)'(fifo_count) - (OCC_W+1)'(res_pop) < (OCC_W+1)'(RES_DEPTH));

    always_comb begin
        ns = state;
        if (frame_err) ns = cfg_loaded ? S_RUN : S_IDLE;
        else if (cfg_fire) ns = last_word ? S_DRAIN : S_LOAD;
        else if (state == S_DRAIN && inflight == '0) ns = S_COMMIT;
        else if (state == S_COMMIT) ns = S_RUN;
    end

    // Handshake enables are registered from the next state so they read 0 throughout reset.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= S_IDLE;
            cfg_ready  <= 1'b0;
            syn_en     <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_loaded <= 1'b0;
            cnt        <= '0;
            shadow     <= '0;
            nn_weights <= '0;
            nn_bias    <= '0;
        end else begin
            state     <= ns;
            cfg_ready <= ns inside {S_IDLE, S_LOAD, S_RUN};
            syn_en    <= ns == S_RUN || (ns == S_LOAD && cfg_loaded);
            cfg_err   <= frame_err;
            if (cfg_fire) begin
                shadow[cnt*WEIGHT_BITS +: WEIGHT_BITS] <= cfg_data;
                cnt <= frame_err || last_word ? '0 : cnt + 1'b1;
            end
            if (state == S_COMMIT) begin
                nn_weights <= shadow[N_W*WEIGHT_BITS-1:0];
                nn_bias    <= shadow[N_CFG*WEIGHT_BITS-1:N_W*WEIGHT_BITS];
                cfg_loaded <= 1'b1;
            end
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            nn_inputs <= '0;
            tags      <= '0;
            inflight  <= '0;
        end else begin
            if (syn_fire) nn_inputs <= syn_data;
            tags     <= {tags[NN_LATENCY-2:0], syn_fire};
            inflight <= inflight + OCC_W'(syn_fire) - OCC_W'(emerge);
        end

    nn_res_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (emerge),
        .push_data (nn_outputs),
        .pop       (res_pop),
        .head      (res_data),
        .count     (fifo_count)
    );
endmodule
